// File: rtl/arp_resolver.sv
// Next-hop MAC resolver: cache lookup first, then ARP request/timeout/retry,
// with every received ARP reply snooped into the cache.
module arp_resolver #(
   parameter int TIMEOUT_CYCLES = 125000,
   parameter int MAX_RETRY      = 3,
   parameter int TIMER_W        = 17
) (
   input  logic        i_sys_clk,
   input  logic        i_rstn,
   input  logic        i_resolve_req,
   input  logic [31:0] i_resolve_ip,
   output logic        o_resolve_ready,
   output logic        o_resolve_done,
   output logic        o_resolve_ok,
   output logic [47:0] o_resolve_mac,
   output logic        o_lookup_en,
   output logic [31:0] o_lookup_ip,
   input  logic        i_lookup_done,
   input  logic        i_lookup_result,
   input  logic [47:0] i_lookup_mac,
   output logic        o_arp_req_en,
   output logic [31:0] o_arp_req_ip,
   input  logic        i_arp_req_ready,
   input  logic        i_arp_rx_valid,
   input  logic [31:0] i_arp_rx_ip,
   input  logic [47:0] i_arp_rx_mac,
   output logic        o_cache_w_en,
   output logic [31:0] o_cache_w_ip,
   output logic [47:0] o_cache_w_mac
);

   localparam int RETRY_W = $clog2(MAX_RETRY + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_SEND_REQ,
      S_WAIT_REPLY,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          target_q, target_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic                 ok_q, ok_d;
   logic [47:0]          mac_q, mac_d;
   logic                 cache_w_en_q, cache_w_en_d;
   logic [31:0]          cache_w_ip_q, cache_w_ip_d;
   logic [47:0]          cache_w_mac_q, cache_w_mac_d;
   logic                 rx_match;

   assign rx_match = i_arp_rx_valid && (i_arp_rx_ip == target_q);

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d  = state_q;
      target_d = target_q;
      timer_d  = timer_q;
      retry_d  = retry_q;
      ok_d     = ok_q;
      mac_d    = mac_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_resolve_req) begin
               target_d = i_resolve_ip;
               retry_d  = '0;
               state_d  = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (i_lookup_done) begin
               if (i_lookup_result) begin
                  mac_d   = i_lookup_mac;
                  ok_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_SEND_REQ;
               end
            end
         end
         S_SEND_REQ: begin
            // A matching reply abandons the outstanding request.
            if (rx_match) begin
               mac_d   = i_arp_rx_mac;
               ok_d    = 1'b1;
               state_d = S_DONE;
            end else if (i_arp_req_ready) begin
               timer_d = '0;
               retry_d = retry_q + RETRY_W'(1);
               state_d = S_WAIT_REPLY;
            end
         end
         S_WAIT_REPLY: begin
            timer_d = timer_q + TIMER_W'(1);
            if (rx_match) begin
               mac_d   = i_arp_rx_mac;
               ok_d    = 1'b1;
               state_d = S_DONE;
            end else if (timer_q == TIMER_LAST) begin
               if (retry_q == RETRY_LAST) begin
                  mac_d   = '0;
                  ok_d    = 1'b0;
                  state_d = S_DONE;
               end else begin
                  state_d = S_SEND_REQ;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Every reply is written to the cache, matching or not.
   always_comb begin
      cache_w_en_d  = i_arp_rx_valid;
      cache_w_ip_d  = cache_w_ip_q;
      cache_w_mac_d = cache_w_mac_q;
      if (i_arp_rx_valid) begin
         cache_w_ip_d  = i_arp_rx_ip;
         cache_w_mac_d = i_arp_rx_mac;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_sys_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q       <= S_IDLE;
         target_q      <= '0;
         timer_q       <= '0;
         retry_q       <= '0;
         ok_q          <= 1'b0;
         mac_q         <= '0;
         cache_w_en_q  <= 1'b0;
         cache_w_ip_q  <= '0;
         cache_w_mac_q <= '0;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         timer_q       <= timer_d;
         retry_q       <= retry_d;
         ok_q          <= ok_d;
         mac_q         <= mac_d;
         cache_w_en_q  <= cache_w_en_d;
         cache_w_ip_q  <= cache_w_ip_d;
         cache_w_mac_q <= cache_w_mac_d;
      end
   end

   assign o_resolve_ready = (state_q == S_IDLE);
   assign o_resolve_done  = (state_q == S_DONE);
   assign o_resolve_ok    = ok_q;
   assign o_resolve_mac   = mac_q;
   assign o_lookup_en     = (state_q == S_LOOKUP);
   assign o_lookup_ip     = target_q;
   assign o_arp_req_en    = (state_q == S_SEND_REQ);
   assign o_arp_req_ip    = target_q;
   assign o_cache_w_en    = cache_w_en_q;
   assign o_cache_w_ip    = cache_w_ip_q;
   assign o_cache_w_mac   = cache_w_mac_q;

endmodule
